matrix_ctrl: RTL and testbench
==============================

# matrix_ctrl

Sequencing controller for the matrix datapath (A ROM, X buffer, ALU, write-back, SRAM).
- Accepts a host job request and streams X words into the buffer.
- Steps the ALU through the four column passes, with a watchdog on each pass.
- Arbitrates host result reads to the SRAM read port so that reads never overlap a running job.
- Sits between the APB slave front-end and the datapath top, and drives all of the datapath's control inputs.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12, SRAM read-address width (APB slaves are 4KB).
- TIMEOUT, 1023, maximum cycles per column pass or per read before error; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle job request.
- abort  in  1  synchronous soft clear to IDLE.
- wr_valid  in  1  host X word present (data bus goes straight to datapath).
- wr_ready  out  1  X word accepted this cycle.
- load_en  out  1  to datapath: load phase active.
- valid_input  out  1  to datapath: X word strobe.
- load_done  in  1  from datapath: buffer full.
- ALU_en  out  1  to datapath: pass enable.
- col_counter  out  2  to datapath: current column pass 0..3.
- cal_finish  in  1  from datapath: current pass written back.
- rd_req  in  1  host read request.
- rd_addr  in  APB_ADDR_WIDTH  host read address.
- rd_ready  out  1  read request accepted.
- read_n  out  1  to SRAM: active-low read strobe.
- r_addr  out  APB_ADDR_WIDTH  to SRAM: read address.
- ry  in  1  from SRAM: read data valid.
- rd_valid  out  1  one-cycle pulse, data_out valid.
- busy  out  1  job running.
- done  out  1  sticky job complete.
- err  out  1  sticky timeout.

## Operation
Job FSM states: IDLE, LOAD, RUN, GAP, DONE, ERR.
- IDLE/DONE/ERR, start=1 → LOAD. done and err clear; col_counter resets to 0.
- LOAD: load_en=1 and wr_ready=1.
  - valid_input = wr_valid & wr_ready, combinational.
  - load_done=1 → RUN. A word presented in the same cycle as load_done is still accepted.
- RUN: ALU_en=1 and the watchdog counts.
  - cal_finish with col_counter<3 → GAP.
  - cal_finish with col_counter==3 → DONE, done=1.
  - Watchdog reaches TIMEOUT without cal_finish → ERR, err=1.
- GAP: one cycle with ALU_en=0; col_counter increments; watchdog clears → RUN.
- busy=1 in LOAD, RUN and GAP.
- start while busy is ignored.
- abort (any state) → IDLE on the next edge.
  - load_en, ALU_en and col_counter clear; done and err clear.
  - Any outstanding read is dropped: read_n=1, no rd_valid.

Read FSM states: R_IDLE, R_WAIT.
- rd_ready = R_IDLE & job state in {IDLE, DONE, ERR} & !start, combinational. start wins over a simultaneous rd_req.
- rd_req & rd_ready → R_WAIT, r_addr <= rd_addr, read_n=0.
- R_WAIT: read_n stays 0 until ry=1. Then: rd_valid pulses 1 cycle, read_n=1, → R_IDLE.
- ry wait reaching TIMEOUT → R_IDLE, err=1, no rd_valid.
- The read watchdog is independent of the job watchdog.

## Timing
- All outputs reset to 0, except read_n=1. Job FSM resets to IDLE, read FSM to R_IDLE.
- Reset is asynchronous mid-operation: everything returns to reset values immediately.
- All outputs are registered from state, except wr_ready, valid_input and rd_ready.
- Edge-by-edge latencies:
  - start at edge N → load_en=1 from N+1.
  - load_done at N → ALU_en=1 from N+1.
  - cal_finish at N (col<3) → ALU_en=0 during N+1, col_counter+1 and ALU_en=1 from N+2.
  - Last cal_finish at N → done=1 and ALU_en=0 from N+1.
- Minimum job length: 1 start + load cycles + 4 passes + 3 GAP cycles.
- Read: accept at N → read_n=0 from N+1. ry at M → rd_valid=1 during M+1 only.
- cal_finish outside RUN and load_done outside LOAD are ignored.

## Test plan
- Full job: start, 8 X words with load_done on the 8th → col_counter steps 0,1,2,3 with one ALU_en=0 gap between passes; done=1 after the 4th cal_finish; busy is 1 throughout, then 0.
- Readback: after done, rd_req addr 0x004, ry 2 cycles later → read_n low for those cycles, r_addr=0x004, rd_valid is a single pulse; rd_req during RUN → rd_ready=0, read_n stays 1.
- Watchdog: TIMEOUT=15, cal_finish withheld in pass 1 → err=1 exactly 15 RUN cycles after pass entry, ALU_en=0; a subsequent start clears err and reloads.
- Simultaneous start+rd_req in DONE → LOAD entered, rd_ready=0, no read issued.
- Abort in GAP of pass 2 → IDLE next cycle, col_counter=0, busy=0, done=0; async rst during LOAD → all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/matrix_ctrl.sv
// matrix_ctrl: job sequencer for the matrix datapath (X load, four ALU column
// passes with a per-pass watchdog) plus the host SRAM read arbiter between jobs.
module matrix_ctrl #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT        = 1023
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   output logic                      load_en,
   output logic                      valid_input,
   input  logic                      load_done,
   output logic                      ALU_en,
   output logic [1:0]                col_counter,
   input  logic                      cal_finish,
   input  logic                      rd_req,
   input  logic [APB_ADDR_WIDTH-1:0] rd_addr,
   output logic                      rd_ready,
   output logic                      read_n,
   output logic [APB_ADDR_WIDTH-1:0] r_addr,
   input  logic                      ry,
   output logic                      rd_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WD_ONE  = CW'(1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   localparam logic R_IDLE = 1'b0;
   localparam logic R_WAIT = 1'b1;

   logic [2:0]                state_q, state_d;
   logic [1:0]                col_q, col_d;
   logic [CW-1:0]             wd_q, wd_d;
   logic                      err_q, err_d;
   logic                      rstate_q, rstate_d;
   logic [CW-1:0]             rwd_q, rwd_d;
   logic [APB_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
   logic                      read_n_q, read_n_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      load_en_q, alu_en_q, busy_q, done_q;
   logic                      job_idle;

   assign job_idle    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
   assign wr_ready    = (state_q == S_LOAD);
   assign valid_input = wr_valid & wr_ready;
   // start takes priority over a simultaneous read request
   assign rd_ready    = (rstate_q == R_IDLE) && job_idle && !start;

   assign load_en     = load_en_q;
   assign ALU_en      = alu_en_q;
   assign col_counter = col_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign read_n      = read_n_q;
   assign r_addr      = r_addr_q;
   assign rd_valid    = rd_valid_q;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      wd_d       = wd_q;
      err_d      = err_q;
      rstate_d   = rstate_q;
      rwd_d      = rwd_q;
      r_addr_d   = r_addr_q;
      read_n_d   = read_n_q;
      rd_valid_d = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LOAD;
               col_d   = 2'd0;
               err_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            if (load_done) begin
               state_d = S_RUN;
               wd_d    = '0;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_RUN: begin
            if (cal_finish) begin
               wd_d    = '0;
               state_d = (col_q == 2'd3) ? S_DONE : S_GAP;
            end else if (wd_q == WD_LAST) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end
         S_GAP: begin
            state_d = S_RUN;
            col_d   = col_q + 2'd1;
            wd_d    = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (rstate_q)
         R_IDLE: begin
            if (rd_req && rd_ready) begin
               rstate_d = R_WAIT;
               r_addr_d = rd_addr;
               read_n_d = 1'b0;
               rwd_d    = '0;
            end else begin
               rstate_d = R_IDLE;
            end
         end
         R_WAIT: begin
            if (ry) begin
               rstate_d   = R_IDLE;
               rd_valid_d = 1'b1;
               read_n_d   = 1'b1;
            end else if (rwd_q == WD_LAST) begin
               rstate_d = R_IDLE;
               read_n_d = 1'b1;
               err_d    = 1'b1;
            end else begin
               rwd_d = rwd_q + WD_ONE;
            end
         end
         default: begin
            rstate_d = R_IDLE;
            read_n_d = 1'b1;
         end
      endcase

      // abort overrides every other transition and drops any outstanding read
      if (abort) begin
         state_d    = S_IDLE;
         col_d      = 2'd0;
         wd_d       = '0;
         err_d      = 1'b0;
         rstate_d   = R_IDLE;
         rwd_d      = '0;
         read_n_d   = 1'b1;
         rd_valid_d = 1'b0;
      end else begin
         rd_valid_d = rd_valid_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         col_q      <= 2'd0;
         wd_q       <= '0;
         err_q      <= 1'b0;
         rstate_q   <= R_IDLE;
         rwd_q      <= '0;
         r_addr_q   <= '0;
         read_n_q   <= 1'b1;
         rd_valid_q <= 1'b0;
         load_en_q  <= 1'b0;
         alu_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
         rstate_q   <= rstate_d;
         rwd_q      <= rwd_d;
         r_addr_q   <= r_addr_d;
         read_n_q   <= read_n_d;
         rd_valid_q <= rd_valid_d;
         load_en_q  <= (state_d == S_LOAD);
         alu_en_q   <= (state_d == S_RUN);
         busy_q     <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_GAP);
         done_q     <= (state_d == S_DONE);
      end
   end

endmodule

// File: tb/tb_matrix_ctrl.sv
// Self-checking bench for matrix_ctrl: randomized jobs and reads checked against
// expectations derived from job shape (word count, pass lengths, read latency).
module tb_matrix_ctrl;

   localparam int AW = 12;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst, start, abort, wr_valid, load_done, cal_finish, rd_req, ry;
   logic [AW-1:0] rd_addr;
   logic          wr_ready, load_en, valid_input, ALU_en, rd_ready, read_n, rd_valid;
   logic          busy, done, err;
   logic [1:0]    col_counter;
   logic [AW-1:0] r_addr;

   int total = 0;
   int bad = 0;
   int busy_cnt = 0;
   int plen [4];

   always #5 clk = ~clk;

   matrix_ctrl #(.APB_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .load_en(load_en),
      .valid_input(valid_input), .load_done(load_done), .ALU_en(ALU_en),
      .col_counter(col_counter), .cal_finish(cal_finish), .rd_req(rd_req),
      .rd_addr(rd_addr), .rd_ready(rd_ready), .read_n(read_n), .r_addr(r_addr),
      .ry(ry), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_load_en"}, load_en, 1'b0);
      chk({tag, "_alu_en"}, ALU_en, 1'b0);
      chkv({tag, "_col"}, 32'(col_counter), 32'd0);
      chk({tag, "_read_n"}, read_n, 1'b1);
      chkv({tag, "_r_addr"}, 32'(r_addr), 32'd0);
      chk({tag, "_rd_valid"}, rd_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_wr_ready"}, wr_ready, 1'b0);
   endtask

   // One job: start, nwords X words with random gaps, then passes of plen[] cycles.
   // hang_pass withholds cal_finish in that pass; abort_pass aborts in the following gap.
   task automatic run_job(input int nwords, input int hang_pass, input int abort_pass);
      int acc;
      int load_cyc;
      int sum;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += plen[i];
      busy_cnt = 0;
      start = 1'b1;
      #1 chk("rd_ready_at_start", rd_ready, 1'b0);
      step();
      start = 1'b0;
      chk("start_load_en", load_en, 1'b1);
      chk("start_busy", busy, 1'b1);
      chk("start_done_clr", done, 1'b0);
      chk("start_err_clr", err, 1'b0);
      chkv("start_col", 32'(col_counter), 32'd0);
      chk("start_alu_off", ALU_en, 1'b0);

      acc = 0;
      load_cyc = 0;
      while (acc < nwords) begin
         wr_valid   = ($urandom_range(0, 3) != 0);
         load_done  = wr_valid && (acc == nwords - 1);
         cal_finish = 1'($urandom_range(0, 1));
         #1;
         chk("load_wr_ready", wr_ready, 1'b1);
         chk("load_valid_input", valid_input, wr_valid);
         if (wr_valid) acc++;
         step();
         load_cyc++;
      end
      wr_valid = 1'b0; load_done = 1'b0; cal_finish = 1'b0;
      chk("run_alu_en", ALU_en, 1'b1);
      chk("run_load_en", load_en, 1'b0);
      chk("run_wr_ready", wr_ready, 1'b0);
      chkv("run_col0", 32'(col_counter), 32'd0);

      for (int p = 0; p < 4; p++) begin
         if (p == hang_pass) begin
            for (int k = 1; k < TO; k++) begin
               step();
               chk("wd_no_err_yet", err, 1'b0);
               chk("wd_alu_on", ALU_en, 1'b1);
            end
            step();
            chk("wd_err", err, 1'b1);
            chk("wd_alu_off", ALU_en, 1'b0);
            chk("wd_busy", busy, 1'b0);
            chk("wd_done", done, 1'b0);
            chkv("wd_col", 32'(col_counter), 32'(p));
            return;
         end
         for (int k = 1; k < plen[p]; k++) begin
            rd_req    = 1'($urandom_range(0, 1));
            rd_addr   = AW'($urandom);
            load_done = 1'($urandom_range(0, 1));
            #1 chk("run_rd_ready", rd_ready, 1'b0);
            step();
            rd_req = 1'b0; load_done = 1'b0;
            chk("run_read_n", read_n, 1'b1);
            chk("run_alu_hold", ALU_en, 1'b1);
            chkv("run_col", 32'(col_counter), 32'(p));
         end
         cal_finish = 1'b1;
         step();
         cal_finish = 1'b0;
         if (p < 3) begin
            chk("gap_alu_off", ALU_en, 1'b0);
            chk("gap_busy", busy, 1'b1);
            chkv("gap_col", 32'(col_counter), 32'(p));
            if (p == abort_pass) begin
               abort = 1'b1;
               step();
               abort = 1'b0;
               chk("abort_busy", busy, 1'b0);
               chkv("abort_col", 32'(col_counter), 32'd0);
               chk("abort_alu", ALU_en, 1'b0);
               chk("abort_done", done, 1'b0);
               chk("abort_load_en", load_en, 1'b0);
               return;
            end
            step();
            chk("next_pass_alu", ALU_en, 1'b1);
            chkv("next_pass_col", 32'(col_counter), 32'(p + 1));
         end else begin
            chk("job_done", done, 1'b1);
            chk("job_alu_off", ALU_en, 1'b0);
            chk("job_busy_off", busy, 1'b0);
            chkv("job_col3", 32'(col_counter), 32'd3);
            chkv("job_busy_cycles", 32'(busy_cnt), 32'(load_cyc + sum + 3));
         end
      end
   endtask

   // Read accepted, ry after 'delay' wait cycles, expect a single rd_valid pulse.
   task automatic do_read(input logic [AW-1:0] addr, input int delay);
      rd_req = 1'b1; rd_addr = addr;
      #1 chk("rd_ready_idle", rd_ready, 1'b1);
      step();
      rd_req = 1'b0;
      chk("rd_read_n_low", read_n, 1'b0);
      chkv("rd_r_addr", 32'(r_addr), 32'(addr));
      chk("rd_no_valid_yet", rd_valid, 1'b0);
      for (int k = 0; k < delay; k++) begin
         step();
         chk("rd_wait_read_n", read_n, 1'b0);
         chk("rd_wait_valid", rd_valid, 1'b0);
      end
      ry = 1'b1;
      step();
      ry = 1'b0;
      chk("rd_valid_pulse", rd_valid, 1'b1);
      chk("rd_read_n_high", read_n, 1'b1);
      step();
      chk("rd_valid_single", rd_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; load_done = 1'b0;
      cal_finish = 1'b0; rd_req = 1'b0; ry = 1'b0; rd_addr = '0;
      step(); step();
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      // full job with 8 words, then the directed readback
      for (int i = 0; i < 4; i++) plen[i] = $urandom_range(1, 10);
      run_job(8, -1, -1);
      do_read(12'h004, 2);
      for (int i = 0; i < 3; i++) do_read(AW'($urandom), $urandom_range(0, 6));

      // read watchdog: ry never comes
      rd_req = 1'b1; rd_addr = 12'h0a5;
      step();
      rd_req = 1'b0;
      for (int k = 1; k < TO; k++) begin
         step();
         chk("rto_read_n", read_n, 1'b0);
         chk("rto_no_err", err, 1'b0);
      end
      step();
      chk("rto_err", err, 1'b1);
      chk("rto_read_n_high", read_n, 1'b1);
      chk("rto_no_valid", rd_valid, 1'b0);
      chk("rto_done_kept", done, 1'b1);

      // random jobs interleaved with reads
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 4; i++) plen[i] = $urandom_range(1, 10);
         run_job($urandom_range(1, 10), -1, -1);
         do_read(AW'($urandom), $urandom_range(0, 6));
      end

      // job watchdog in pass 1, then a start clears err and reloads
      for (int i = 0; i < 4; i++) plen[i] = $urandom_range(1, 10);
      run_job(5, 1, -1);
      run_job(3, -1, -1);

      // start and rd_req together in DONE
      start = 1'b1; rd_req = 1'b1; rd_addr = 12'h123;
      #1 chk("sim_rd_ready", rd_ready, 1'b0);
      step();
      start = 1'b0; rd_req = 1'b0;
      chk("sim_load_en", load_en, 1'b1);
      chk("sim_read_n", read_n, 1'b1);
      step();
      chk("sim_read_n_hold", read_n, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("sim_abort_idle", busy, 1'b0);

      // abort in the gap after pass 2
      for (int i = 0; i < 4; i++) plen[i] = $urandom_range(1, 6);
      run_job(4, -1, 2);

      // abort drops an outstanding read
      rd_req = 1'b1; rd_addr = 12'h3c3;
      step();
      rd_req = 1'b0;
      chk("ard_read_n_low", read_n, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ard_read_n_high", read_n, 1'b1);
      ry = 1'b1;
      step();
      ry = 1'b0;
      chk("ard_no_valid", rd_valid, 1'b0);

      // asynchronous reset in the middle of LOAD
      start = 1'b1;
      step();
      start = 1'b0;
      chk("arst_in_load", load_en, 1'b1);
      wr_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("arst");
      chk("arst_valid_input", valid_input, 1'b0);
      rst = 1'b0; wr_valid = 1'b0;
      step();
      chk("arst_stays_idle", load_en, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
